// File: rtl/picorv_trace_capture.sv
// PicoRV32 instruction-trace capture buffer.
// Records trace words into a circular buffer while armed, freezes a fixed
// number of words after the first trap rising edge, then replays the held
// history oldest-first over a valid/ready read port.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for arm; trace input ignored
//   CAPTURE | recording every valid trace word, watching for a trap edge
//   POST    | recording the post-trigger window, trap edges ignored
//   DONE    | buffer frozen; history streamed out on the read port
module picorv_trace_capture #(
  parameter int DATA_W    = 36,
  parameter int DEPTH     = 256,
  parameter int POST_TRIG = 16
) (
  input  logic                       G0_CPU_CLK,
  input  logic                       G0_CPU_RST,
  input  logic                       arm,
  input  logic                       trace_valid,
  input  logic [DATA_W-1:0]          trace_data,
  input  logic                       trap,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_last,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       wrapped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [AW-1:0] POST_LD  = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_POST    = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t            cur_st, nxt_st;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, post_cnt, start_ptr;
  logic [CW-1:0]     count_q, remain;
  logic              wrapped_q, trap_q, rd_valid_q, dump_init;
  logic [DATA_W-1:0] rd_data_q;
  logic              trig, capturing, wr_en, start, enter_done;

  assign trig       = trap & ~trap_q;
  assign capturing  = (cur_st == S_CAPTURE) || (cur_st == S_POST);
  assign wr_en      = capturing & trace_valid;
  assign start      = arm && ((cur_st == S_IDLE) || (cur_st == S_DONE));
  assign enter_done = (nxt_st == S_DONE) && (cur_st != S_DONE);
  // Once wrapped, the oldest surviving word sits at the next write slot.
  assign start_ptr  = wrapped_q ? wr_ptr : '0;

  assign state    = cur_st;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_valid_q && (remain == CW'(1));

  // State register.
  always_ff @(posedge G0_CPU_CLK or posedge G0_CPU_RST) begin
    if (G0_CPU_RST) cur_st <= S_IDLE;
    else            cur_st <= nxt_st;
  end

  // Next-state decode.
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_IDLE:    if (arm) nxt_st = S_CAPTURE;
      S_CAPTURE: if (trig) nxt_st = (POST_TRIG == 0) ? S_DONE : S_POST;
      S_POST:    if (wr_en && (post_cnt == AW'(1))) nxt_st = S_DONE;
      S_DONE:    if (arm) nxt_st = S_CAPTURE;
      default:   nxt_st = S_IDLE;
    endcase
  end

  // Registered copy of trap for edge detection, live in every state.
  always_ff @(posedge G0_CPU_CLK or posedge G0_CPU_RST) begin
    if (G0_CPU_RST) trap_q <= 1'b0;
    else            trap_q <= trap;
  end

  // Trace storage; contents need no reset.
  always_ff @(posedge G0_CPU_CLK) begin
    if (wr_en) mem[wr_ptr] <= trace_data;
  end

  // Capture bookkeeping and read-out pipeline.
  always_ff @(posedge G0_CPU_CLK or posedge G0_CPU_RST) begin
    if (G0_CPU_RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      post_cnt   <= '0;
      remain     <= '0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      dump_init  <= 1'b0;
    end else begin
      dump_init <= enter_done;
      if (start) begin
        wr_ptr     <= '0;
        count_q    <= '0;
        wrapped_q  <= 1'b0;
        rd_valid_q <= 1'b0;
        remain     <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (count_q == FULL) wrapped_q <= 1'b1;
          else                 count_q   <= count_q + 1'b1;
        end
        if ((cur_st == S_CAPTURE) && trig)    post_cnt <= POST_LD;
        else if ((cur_st == S_POST) && wr_en) post_cnt <= post_cnt - 1'b1;
        // Read-out starts one cycle after DONE so pointer/count are final.
        if (cur_st == S_DONE) begin
          if (dump_init) begin
            rd_data_q  <= mem[start_ptr];
            rd_ptr     <= start_ptr + 1'b1;
            remain     <= count_q;
            rd_valid_q <= (count_q != '0);
          end else if (rd_valid_q && rd_ready) begin
            remain <= remain - 1'b1;
            if (remain == CW'(1)) begin
              rd_valid_q <= 1'b0;
            end else begin
              rd_data_q <= mem[rd_ptr];
              rd_ptr    <= rd_ptr + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_picorv_trace_capture.sv
// Directed self-checking bench for picorv_trace_capture.
// Three instances share stimulus: A (256/16), B (16/4), C (8/0).
module tb_picorv_trace_capture;

  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          tv  = 1'b0;
  logic [DW-1:0] td  = '0;
  logic          trap = 1'b0;
  logic          rd_ready = 1'b0;

  logic          a_rv, a_rl, a_wr;
  logic [DW-1:0] a_rd;
  logic [1:0]    a_st;
  logic [8:0]    a_cnt;
  logic          b_rv, b_rl, b_wr;
  logic [DW-1:0] b_rd;
  logic [1:0]    b_st;
  logic [4:0]    b_cnt;
  logic          c_rv, c_rl, c_wr;
  logic [DW-1:0] c_rd;
  logic [1:0]    c_st;
  logic [3:0]    c_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  picorv_trace_capture #(.DATA_W(DW), .DEPTH(256), .POST_TRIG(16)) dut_a (
    .G0_CPU_CLK(clk), .G0_CPU_RST(rst), .arm(arm), .trace_valid(tv),
    .trace_data(td), .trap(trap), .rd_valid(a_rv), .rd_ready(rd_ready),
    .rd_data(a_rd), .rd_last(a_rl), .state(a_st), .count(a_cnt), .wrapped(a_wr));

  picorv_trace_capture #(.DATA_W(DW), .DEPTH(16), .POST_TRIG(4)) dut_b (
    .G0_CPU_CLK(clk), .G0_CPU_RST(rst), .arm(arm), .trace_valid(tv),
    .trace_data(td), .trap(trap), .rd_valid(b_rv), .rd_ready(rd_ready),
    .rd_data(b_rd), .rd_last(b_rl), .state(b_st), .count(b_cnt), .wrapped(b_wr));

  picorv_trace_capture #(.DATA_W(DW), .DEPTH(8), .POST_TRIG(0)) dut_c (
    .G0_CPU_CLK(clk), .G0_CPU_RST(rst), .arm(arm), .trace_valid(tv),
    .trace_data(td), .trap(trap), .rd_valid(c_rv), .rd_ready(rd_ready),
    .rd_data(c_rd), .rd_last(c_rl), .state(c_st), .count(c_cnt), .wrapped(c_wr));

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; tv = 1'b0; td = '0; rd_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic push(input int value);
    tv = 1'b1; td = DW'(value); step(); tv = 1'b0;
  endtask

  task automatic test_reset();
    trap = 1'b0;
    do_reset();
    vectors++; if (a_st !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", a_st); end
    vectors++; if (a_cnt !== 9'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
    vectors++; if (a_wr !== 1'b0) begin errors++; $display("FAIL reset_wrapped got %b exp 0", a_wr); end
    vectors++; if (a_rv !== 1'b0 || a_rl !== 1'b0) begin errors++; $display("FAIL reset_rd got v=%b l=%b exp 0 0", a_rv, a_rl); end
    vectors++; if (a_rd !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", a_rd); end
    push(7); push(8);
    vectors++; if (a_cnt !== 9'd0 || a_st !== 2'b00) begin errors++; $display("FAIL idle_ignore got cnt=%0d st=%b exp 0 00", a_cnt, a_st); end
  endtask

  task automatic test_basic_post4();
    do_reset();
    rd_ready = 1'b1;
    pulse_arm();
    vectors++; if (b_st !== 2'b01) begin errors++; $display("FAIL b_arm_state got %b exp 01", b_st); end
    for (int i = 0; i < 10; i++) push(i);
    trap = 1'b1; step();
    vectors++; if (b_st !== 2'b10) begin errors++; $display("FAIL b_post_state got %b exp 10", b_st); end
    for (int i = 10; i < 14; i++) push(i);
    vectors++; if (b_st !== 2'b11) begin errors++; $display("FAIL b_done_state got %b exp 11", b_st); end
    vectors++; if (b_cnt !== 5'd14) begin errors++; $display("FAIL b_count got %0d exp 14", b_cnt); end
    vectors++; if (b_wr !== 1'b0) begin errors++; $display("FAIL b_wrapped got %b exp 0", b_wr); end
    vectors++; if (b_rv !== 1'b0) begin errors++; $display("FAIL b_latency got %b exp 0", b_rv); end
    step();
    for (int k = 0; k < 14; k++) begin
      vectors++;
      if (b_rv !== 1'b1 || b_rd !== DW'(k) || b_rl !== (k == 13)) begin
        errors++;
        $display("FAIL b_dump[%0d] got v=%b d=%h l=%b exp 1 %h %b", k, b_rv, b_rd, b_rl, DW'(k), (k == 13));
      end
      step();
    end
    vectors++; if (b_rv !== 1'b0 || b_st !== 2'b11) begin errors++; $display("FAIL b_after_dump got v=%b st=%b exp 0 11", b_rv, b_st); end
    trap = 1'b0;
  endtask

  task automatic test_wrap_256();
    do_reset();
    rd_ready = 1'b1;
    pulse_arm();
    for (int i = 0; i < 300; i++) push(i);
    trap = 1'b1; step();
    for (int i = 300; i < 316; i++) push(i);
    trap = 1'b0;
    vectors++; if (a_st !== 2'b11) begin errors++; $display("FAIL a_done_state got %b exp 11", a_st); end
    vectors++; if (a_cnt !== 9'd256) begin errors++; $display("FAIL a_count got %0d exp 256", a_cnt); end
    vectors++; if (a_wr !== 1'b1) begin errors++; $display("FAIL a_wrapped got %b exp 1", a_wr); end
    step();
    for (int k = 0; k < 256; k++) begin
      vectors++;
      if (a_rv !== 1'b1 || a_rd !== DW'(60 + k) || a_rl !== (k == 255)) begin
        errors++;
        $display("FAIL a_dump[%0d] got v=%b d=%0d l=%b exp 1 %0d %b", k, a_rv, a_rd, a_rl, 60 + k, (k == 255));
      end
      step();
    end
    vectors++; if (a_rv !== 1'b0) begin errors++; $display("FAIL a_after_dump got %b exp 0", a_rv); end
  endtask

  task automatic test_post0();
    do_reset();
    rd_ready = 1'b1;
    pulse_arm();
    trap = 1'b1; step(); trap = 1'b0;
    vectors++; if (c_st !== 2'b11 || c_cnt !== 4'd0) begin errors++; $display("FAIL c_empty got st=%b cnt=%0d exp 11 0", c_st, c_cnt); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (c_rv !== 1'b0) begin errors++; $display("FAIL c_empty_rv[%0d] got %b exp 0", i, c_rv); end
      step();
    end
    pulse_arm();
    push(1); push(2); push(3);
    trap = 1'b1; tv = 1'b1; td = DW'(32'h55); step(); tv = 1'b0; trap = 1'b0;
    vectors++; if (c_st !== 2'b11 || c_cnt !== 4'd4) begin errors++; $display("FAIL c_same_cycle got st=%b cnt=%0d exp 11 4", c_st, c_cnt); end
    step();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (c_rv !== 1'b1 || c_rd !== ((k == 3) ? DW'(32'h55) : DW'(k + 1)) || c_rl !== (k == 3)) begin
        errors++;
        $display("FAIL c_dump[%0d] got v=%b d=%h l=%b", k, c_rv, c_rd, c_rl);
      end
      step();
    end
    vectors++; if (c_rv !== 1'b0) begin errors++; $display("FAIL c_after_dump got %b exp 0", c_rv); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] words [21];
    logic pat [4];
    int  idx;
    int  cyc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    do_reset();
    pulse_arm();
    for (int i = 0; i < 5; i++) begin words[i] = DW'(256 + i); push(256 + i); end
    trap = 1'b1; step();
    for (int i = 0; i < 16; i++) begin words[5 + i] = DW'(512 + i); push(512 + i); end
    trap = 1'b0;
    step();
    idx = 0;
    cyc = 0;
    while (idx < 21 && cyc < 100) begin
      rd_ready = pat[cyc % 4];
      #2;
      vectors++;
      if (a_rv !== 1'b1 || a_rd !== words[idx] || a_rl !== (idx == 20)) begin
        errors++;
        $display("FAIL bp[%0d] got v=%b d=%h l=%b exp 1 %h %b", idx, a_rv, a_rd, a_rl, words[idx], (idx == 20));
      end
      if (rd_ready) idx++;
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    vectors++; if (idx != 21) begin errors++; $display("FAIL bp_timeout got %0d words exp 21", idx); end
    vectors++; if (a_rv !== 1'b0) begin errors++; $display("FAIL bp_after got %b exp 0", a_rv); end
  endtask

  task automatic test_aborts();
    do_reset();
    pulse_arm();
    push(0); push(1); push(2);
    arm = 1'b1; tv = 1'b1; td = DW'(3); step(); arm = 1'b0; tv = 1'b0;
    vectors++; if (a_st !== 2'b01 || a_cnt !== 9'd4) begin errors++; $display("FAIL arm_in_capture got st=%b cnt=%0d exp 01 4", a_st, a_cnt); end
    trap = 1'b1; step();
    for (int i = 0; i < 16; i++) push(100 + i);
    trap = 1'b0;
    step();
    rd_ready = 1'b1; step(); step();
    vectors++; if (a_rv !== 1'b1 || a_rd !== DW'(2)) begin errors++; $display("FAIL mid_dump got v=%b d=%h exp 1 2", a_rv, a_rd); end
    pulse_arm();
    vectors++; if (a_rv !== 1'b0 || a_st !== 2'b01 || a_cnt !== 9'd0 || a_wr !== 1'b0) begin
      errors++; $display("FAIL arm_abort got v=%b st=%b cnt=%0d wr=%b exp 0 01 0 0", a_rv, a_st, a_cnt, a_wr);
    end
    push(9); push(10);
    vectors++; if (a_cnt !== 9'd2) begin errors++; $display("FAIL fresh_capture got %0d exp 2", a_cnt); end
    trap = 1'b1; step(); trap = 1'b0;
    push(11); push(12);
    vectors++; if (a_st !== 2'b10) begin errors++; $display("FAIL pre_rst_post got %b exp 10", a_st); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (a_st !== 2'b00 || a_cnt !== 9'd0 || a_wr !== 1'b0 || a_rv !== 1'b0 || a_rl !== 1'b0 || a_rd !== '0) begin
      errors++; $display("FAIL async_reset got st=%b cnt=%0d wr=%b v=%b l=%b d=%h exp all 0", a_st, a_cnt, a_wr, a_rv, a_rl, a_rd);
    end
    step(); rst = 1'b0; step(); step();
    vectors++; if (a_rv !== 1'b0 || a_st !== 2'b00) begin errors++; $display("FAIL post_release got v=%b st=%b exp 0 00", a_rv, a_st); end
    rd_ready = 1'b0;
  endtask

  task automatic test_trap_held();
    trap = 1'b1;
    do_reset();
    pulse_arm();
    for (int i = 0; i < 5; i++) push(i);
    vectors++; if (a_st !== 2'b01 || a_cnt !== 9'd5) begin errors++; $display("FAIL trap_held got st=%b cnt=%0d exp 01 5", a_st, a_cnt); end
    trap = 1'b0; step();
    vectors++; if (a_st !== 2'b01) begin errors++; $display("FAIL trap_fall got %b exp 01", a_st); end
    trap = 1'b1; step();
    vectors++; if (a_st !== 2'b10) begin errors++; $display("FAIL trap_rise got %b exp 10", a_st); end
    trap = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_post4();
    test_wrap_256();
    test_post0();
    test_backpressure();
    test_aborts();
    test_trap_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/picorv_trace_capture.md
Name: picorv_trace_capture

Overview:
- Synthesizable on-chip receiver for the PicoRV32 instruction-trace port (trace_valid / 36-bit trace_data) inside picorv_x_pulp_soc.
- Records trace words into a circular buffer while armed.
- Freezes a configurable number of entries after the first trap rising edge.
- After freezing, streams the captured history oldest-first over a valid/ready read port for a debug master or firmware drain.

Parameters:
- DATA_W, 36: trace word width; must match the core trace_data width.
- DEPTH, 256: buffer entries; power of two, minimum 4.
- POST_TRIG, 16: entries captured after the trap edge before freezing; range 0..DEPTH-1.

Ports:
- G0_CPU_CLK  in  1  core clock; all logic is on the rising edge.
- G0_CPU_RST  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse; clears the buffer and starts capture.
- trace_valid  in  1  trace word qualifier from the core.
- trace_data  in  DATA_W  trace word.
- trap  in  1  core trap level.
- rd_valid  out  1  read word available.
- rd_ready  in  1  read consumer accept.
- rd_data  out  DATA_W  oldest unread captured word.
- rd_last  out  1  high with the final word of the dump.
- state  out  2  00 IDLE, 01 CAPTURE, 10 POST, 11 DONE.
- count  out  $clog2(DEPTH)+1  valid entries held; saturates at DEPTH.
- wrapped  out  1  at least one entry has been overwritten since arm.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; wr_ptr, rd_ptr, count, post_cnt all 0.
  - wrapped=0, rd_valid=0, rd_last=0, rd_data=0, trap_q=0.
  - Buffer contents are don't-care.
  - Reset mid-capture or mid-dump abandons all data; no partial output follows release.
- trap_q is a registered copy of trap. Trigger = trap & ~trap_q. trap_q updates in every state.
- IDLE:
  - trace_valid is ignored.
  - arm moves to CAPTURE next cycle with wr_ptr=0, count=0, wrapped=0.
- CAPTURE:
  - Each cycle with trace_valid=1: write mem[wr_ptr]=trace_data; wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH.
  - A write while count==DEPTH sets wrapped=1; wrapped stays set until the next arm.
  - On trigger:
    - A trace_valid in the same cycle is still captured.
    - If POST_TRIG=0, go to DONE.
    - Otherwise go to POST with post_cnt=POST_TRIG.
- POST:
  - Captures exactly as in CAPTURE.
  - post_cnt decrements per captured word.
  - The cycle that captures the word taking post_cnt to 0 also transitions to DONE.
  - Further trap edges are ignored.
- arm is ignored in CAPTURE and POST.
- DONE:
  - trace_valid is ignored.
  - On entry, rd_ptr = wrapped ? wr_ptr : 0, and the remaining-words counter loads count.
  - Read latency: rd_valid rises 1 cycle after entering DONE, with the oldest word.
  - Transfer occurs on rd_valid & rd_ready.
  - The next word is presented on the following cycle with no bubble; sustained 1 word per clock.
  - rd_data and rd_last are held stable while rd_valid=1 and rd_ready=0.
  - rd_last=1 exactly when the remaining-words counter is 1.
  - After the last transfer, rd_valid=0 and the block stays in DONE.
  - count is not decremented by reads; it remains a record of the capture.
  - If count=0 on entry, rd_valid never asserts.
- arm in DONE, including mid-dump, aborts the dump immediately:
  - rd_valid=0 on the next cycle.
  - Then same as arm from IDLE.
- Pointer arithmetic is unsigned, modulo DEPTH.
- Storage: the implementation may use a register array or a 1R1W SRAM with a prefetch stage. Externally visible timing must match the above.

Test Plan:
- Reset, arm, 10 trace words 0x0..0x9, trap edge after word 9, POST_TRIG=4, 4 more words 0xA..0xD -> state=DONE; count=14; wrapped=0; dump 0x0..0xD in order; rd_last on 0xD.
- DEPTH=256: arm, 300 words 0..299, trap, 16 post words 300..315 -> count=256; wrapped=1; dump 60..315; rd_last on 315.
- POST_TRIG=0 with trap and trace_valid in the same cycle carrying 0x55 -> 0x55 is the final dumped word; DONE entered the next cycle.
- Readout backpressure: rd_ready toggling 1,0,0,1 -> rd_data is held during the stall; no word dropped or duplicated. rd_ready held high -> one word per clock.
- Abort cases:
  - arm mid-dump -> rd_valid drops the next cycle; fresh capture starts with count=0.
  - arm during CAPTURE -> ignored.
  - G0_CPU_RST asserted during POST -> state=IDLE and all outputs 0 asynchronously.
- Trap held high continuously across arm -> no trigger until trap falls and rises again; capture continues meanwhile.
